// File: rtl/scoreboard_scan.sv
// scoreboard_scan: converts a 14-bit binary score to four BCD digits with a
// sequential double-dabble engine and time-multiplexes them onto a 7-segment
// display through a 2-bit digit select.
module scoreboard_scan #(
    parameter int unsigned DIV      = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] score,
    input  logic        score_valid,
    output logic        busy,
    output logic [1:0]  sel,
    output logic [6:0]  seg
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t      state, state_nxt;
    logic [13:0] shreg;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic [3:0]  iter;
    logic [3:0]  dig [4];
    logic [3:0]  blank;
    logic [CW-1:0] cnt;
    logic        tick;
    logic [1:0]  sel_nxt;

    function automatic logic [6:0] enc(input logic [3:0] d, input logic blk);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'h3F;
            4'd1: p = 7'h06;
            4'd2: p = 7'h5B;
            4'd3: p = 7'h4F;
            4'd4: p = 7'h66;
            4'd5: p = 7'h6D;
            4'd6: p = 7'h7D;
            4'd7: p = 7'h07;
            4'd8: p = 7'h7F;
            4'd9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return blk ? 7'h00 : p;
    endfunction

    // Conversion FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: load only from IDLE, 14 shift cycles, one commit cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (score_valid) state_nxt = SHIFT;
            SHIFT:   if (iter == 4'd13) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that is 5 or more before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath, digit registers and the delayed busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bcd    <= '0;
            iter   <= '0;
            dig[0] <= '0;
            dig[1] <= '0;
            dig[2] <= '0;
            dig[3] <= '0;
            busy   <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        shreg <= (score > 14'd9999) ? 14'd9999 : score;
                        bcd   <= '0;
                        iter  <= '0;
                    end
                end
                SHIFT: begin
                    bcd   <= {bcd_adj[14:0], shreg[13]};
                    shreg <= {shreg[12:0], 1'b0};
                    iter  <= iter + 4'd1;
                end
                COMMIT: begin
                    dig[0] <= bcd[3:0];
                    dig[1] <= bcd[7:4];
                    dig[2] <= bcd[11:8];
                    dig[3] <= bcd[15:12];
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking mask; the units digit is always shown.
    always_comb begin
        blank    = '0;
        blank[3] = BLANK_LZ && (dig[3] == 4'd0);
        blank[2] = blank[3] && (dig[2] == 4'd0);
        blank[1] = blank[2] && (dig[1] == 4'd0);
    end

    assign tick    = (cnt == CW'(DIV - 1));
    assign sel_nxt = sel + 2'd1;

    // Scan prescaler and display registers; seg is loaded for the new sel on tick
    // from the digit registers as they stood before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sel <= '0;
            seg <= 7'h3F;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                sel <= sel_nxt;
                seg <= enc(dig[sel_nxt], blank[sel_nxt]);
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_scan.sv
// Self-checking bench for scoreboard_scan: three instances (DIV=4 with and
// without blanking, DIV=1) share stimulus and are compared every cycle against
// an arithmetic model of the displayed score, plus literal spot checks.
module tb_scoreboard_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] score = '0;
    logic        score_valid = 1'b0;
    logic        busy_a [3];
    logic [1:0]  sel_a  [3];
    logic [6:0]  seg_a  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scoreboard_scan #(.DIV(4), .BLANK_LZ(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .busy(busy_a[0]), .sel(sel_a[0]), .seg(seg_a[0]));
    scoreboard_scan #(.DIV(4), .BLANK_LZ(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .busy(busy_a[1]), .sel(sel_a[1]), .seg(seg_a[1]));
    scoreboard_scan #(.DIV(1), .BLANK_LZ(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .busy(busy_a[2]), .sel(sel_a[2]), .seg(seg_a[2]));

    int div_of [3] = '{4, 4, 1};
    bit blz_of [3] = '{1'b1, 1'b0, 1'b1};

    // ---------------- model ----------------
    int e;            // edges since reset release
    int load_edge;
    int commit_edge;
    int pending;
    int disp;         // committed score value
    int exp_sel [3];
    int exp_seg [3];
    int exp_busy;

    function automatic int p10(int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int pat(int k, int v, bit blz);
        int d;
        d = (v / p10(k)) % 10;
        if (blz && k > 0 && v < p10(k)) return 0;
        case (d)
            0: return 'h3F; 1: return 'h06; 2: return 'h5B; 3: return 'h4F;
            4: return 'h66; 5: return 'h6D; 6: return 'h7D; 7: return 'h07;
            8: return 'h7F; default: return 'h6F;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0; load_edge = -100; commit_edge = -1; pending = 0; disp = 0; exp_busy = 0;
            for (int i = 0; i < 3; i++) begin
                exp_sel[i] = 0;
                exp_seg[i] = pat(0, 0, blz_of[i]);
            end
        end else begin
            e = e + 1;
            for (int i = 0; i < 3; i++) begin
                if (e % div_of[i] == 0) begin
                    exp_sel[i] = (exp_sel[i] + 1) % 4;
                    exp_seg[i] = pat(exp_sel[i], disp, blz_of[i]);
                end
            end
            if (e == commit_edge) disp = pending;
            exp_busy = (e >= load_edge + 1 && e <= load_edge + 15) ? 1 : 0;
            if (score_valid && e >= load_edge + 16) begin
                load_edge   = e;
                pending     = (int'(score) > 9999) ? 9999 : int'(score);
                commit_edge = e + 15;
            end
        end
    end

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_sel%0d", i), int'(sel_a[i]), exp_sel[i]);
                chk($sformatf("model_seg%0d", i), int'(seg_a[i]), exp_seg[i]);
                chk($sformatf("model_busy%0d", i), int'(busy_a[i]), exp_busy);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(int v);
        @(negedge clk);
        score = 14'(v);
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic wait_sel(int i, int k);
        int n = 0;
        while (int'(sel_a[i]) != k && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (int'(sel_a[i]) != k) chk($sformatf("wait_sel%0d_%0d_timeout", i, k), int'(sel_a[i]), k);
    endtask

    task automatic frame_check(string name, int i, int s0, int s1, int s2, int s3);
        int want [4];
        want = '{s0, s1, s2, s3};
        for (int k = 0; k < 4; k++) begin
            wait_sel(i, k);
            chk($sformatf("%s_i%0d_sel%0d", name, i, k), int'(seg_a[i]), want[k]);
        end
    endtask

    task automatic settle();
        int n = 0;
        while (busy_a[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy_a[0]) chk("busy_timeout", 1, 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        #12;
        chk("rst_sel", int'(sel_a[0]), 0);
        chk("rst_seg", int'(seg_a[0]), 'h3F);
        chk("rst_busy", int'(busy_a[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle scan: sel changes every 4 cycles
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c % 4 == 0) chk($sformatf("idle_sel_c%0d", c), int'(sel_a[0]), (c / 4) % 4);
        end
        frame_check("idle", 0, 'h3F, 'h00, 'h00, 'h00);
        frame_check("idle", 1, 'h3F, 'h3F, 'h3F, 'h3F);

        // 1234: busy length, then digits
        load(1234);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_a[0]) cnt++;
            else if (cnt > 0) break;
        end
        chk("busy_len", cnt, 15);
        settle();
        frame_check("d1234", 0, 'h66, 'h4F, 'h5B, 'h06);

        // saturation
        load(12000);
        settle();
        frame_check("sat", 0, 'h6F, 'h6F, 'h6F, 'h6F);
        load(1);
        settle();
        load(9999);
        settle();
        frame_check("d9999", 0, 'h6F, 'h6F, 'h6F, 'h6F);

        // dropped load while busy
        load(7);
        @(negedge clk);
        score = 14'd5000;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        settle();
        frame_check("drop", 0, 'h07, 'h00, 'h00, 'h00);

        // reset mid-conversion
        load(4321);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_sel", int'(sel_a[0]), 0);
        chk("rstmid_seg", int'(seg_a[0]), 'h3F);
        chk("rstmid_busy", int'(busy_a[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        frame_check("after_rst", 0, 'h3F, 'h00, 'h00, 'h00);
        load(80);
        settle();
        frame_check("d80", 0, 'h3F, 'h7F, 'h00, 'h00);
        frame_check("d80", 1, 'h3F, 'h7F, 'h3F, 'h3F);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
